// File: rtl/if_id_fetch_queue_if.sv
// Fetch-queue bus bundle: PC-side handshake, instruction-memory read port
// and the IF/ID register view presented to decode.
// "slave" is the fetch queue's side of the bundle. "master" is the
// surrounding pipeline and memory side.
interface if_id_fetch_queue_if;
  // PC register side
  logic [31:0] pc_f;
  logic        stall_f;
  // Instruction memory read port
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  // Decode side
  logic        stall_d;
  logic        flush_d;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;

  modport slave (
    input  pc_f,
    output stall_f,
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_rvalid,
    input  stall_d,
    input  flush_d,
    output valid_d,
    output instr_d,
    output pc_plus4_d
  );

  modport master (
    output pc_f,
    input  stall_f,
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_rvalid,
    output stall_d,
    output flush_d,
    input  valid_d,
    input  instr_d,
    input  pc_plus4_d
  );
endinterface

// File: rtl/if_id_fetch_queue.sv
// Fetch-side buffer between the PC register and decode.
// - Issues one instruction read per cycle at pc_f.
// - Queues each returned word together with its pc+4.
// - Presents the queue head as the IF/ID register contents.
// Request issue is credit based: the words already queued, plus any read in
// flight, minus the word decode takes this cycle, may never exceed DEPTH.
// That guarantees every response has a free slot, so nothing is lost or
// duplicated.
module if_id_fetch_queue #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  if_id_fetch_queue_if.slave    bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // pointer width
  localparam int OW = PW + 1;                           // occupancy width (0..DEPTH)
  localparam int CW = OW + 1;                           // credit sum width
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // State
  logic [OW-1:0] occ_q, occ_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc4_q, inflight_pc4_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];
  logic [31:0]   pc4_mem_q   [DEPTH];
  logic [31:0]   pc4_mem_d   [DEPTH];

  // Per-cycle control
  logic          valid_s;
  logic          pop_s;
  logic          push_s;
  logic          can_issue_s;
  logic          issue_s;
  logic [CW-1:0] credit_s;

  // Handshake decode: pop, push, credit check and request issue
  always_comb begin
    valid_s     = (occ_q != {OW{1'b0}});
    pop_s       = valid_s & ~bus.stall_d & ~bus.flush_d;
    // pop implies occ >= 1, so this subtraction never underflows
    credit_s    = {1'b0, occ_q} + {{(CW-1){1'b0}}, inflight_q}
                  - {{(CW-1){1'b0}}, pop_s};
    can_issue_s = (credit_s < DEPTH_C);
    issue_s     = can_issue_s & ~bus.flush_d & ~reset;
    // A response with no matching request (e.g. across a reset) is ignored
    push_s      = bus.imem_rvalid & inflight_q & ~bus.flush_d;
  end

  // Next-state computation for queue, pointers and in-flight tracking
  always_comb begin
    occ_d          = occ_q;
    inflight_d     = inflight_q;
    inflight_pc4_d = inflight_pc4_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    instr_mem_d    = instr_mem_q;
    pc4_mem_d      = pc4_mem_q;

    if (bus.flush_d) begin
      // Redirect: drop queued words and the outstanding read
      occ_d      = {OW{1'b0}};
      inflight_d = 1'b0;
      rd_ptr_d   = {PW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
    end else begin
      if (push_s) begin
        instr_mem_d[wr_ptr_q] = bus.imem_rdata;
        pc4_mem_d[wr_ptr_q]   = inflight_pc4_q;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      occ_d = occ_q + OW'(push_s) - OW'(pop_s);

      if (issue_s) begin
        inflight_d     = 1'b1;
        inflight_pc4_d = bus.pc_f + 32'd4;  // wraps mod 2^32
      end else begin
        inflight_d     = 1'b0;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q          <= {OW{1'b0}};
      inflight_q     <= 1'b0;
      inflight_pc4_q <= 32'h0000_0000;
      rd_ptr_q       <= {PW{1'b0}};
      wr_ptr_q       <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= 32'h0000_0000;
        pc4_mem_q[i]   <= 32'h0000_0000;
      end
    end else begin
      occ_q          <= occ_d;
      inflight_q     <= inflight_d;
      inflight_pc4_q <= inflight_pc4_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      instr_mem_q    <= instr_mem_d;
      pc4_mem_q      <= pc4_mem_d;
    end
  end

  // Drive the PC-side, memory-side and decode-side outputs
  always_comb begin
    bus.imem_req  = issue_s;
    bus.imem_addr = bus.pc_f;
    // During a flush the PC must load the redirect target, so never hold it
    bus.stall_f   = ~can_issue_s & ~bus.flush_d;
    bus.valid_d   = valid_s;
    if (valid_s) begin
      bus.instr_d    = instr_mem_q[rd_ptr_q];
      bus.pc_plus4_d = pc4_mem_q[rd_ptr_q];
    end else begin
      bus.instr_d    = NOP_INSTR;
      bus.pc_plus4_d = 32'h0000_0000;
    end
  end

endmodule
